// File: rtl/relax_osc_freq_counter_if.sv
// Measurement bus between the frequency counter and its consumer:
// oscillator input and start request in, status and latched result out.
interface relax_osc_freq_counter_if #(
  parameter int CNT_W = 16
) ();
  logic             osc_in;
  logic             start;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output osc_in, start,
    input  busy, valid, count, overflow
  );

  modport slave (
    input  osc_in, start,
    output busy, valid, count, overflow
  );
endinterface

// File: rtl/relax_osc_freq_counter.sv
// Gated rising-edge counter for the relaxation oscillator output.
// Define RELAX_OSC_FREQ_CONT_EN for free-running back-to-back windows (DONE -> ARM).
module relax_osc_freq_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  relax_osc_freq_counter_if.slave  bus
);

  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [CNT_W-1:0]       edge_q, edge_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   rise;

  // osc_in is asynchronous; only the last synchroniser stage is trusted.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.osc_in};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
        end
      end
      ARM: begin
        gate_d  = '0;
        edge_d  = '0;
        ovf_d   = 1'b0;
        state_d = GATE;
      end
      GATE: begin
        if (rise) begin
          if (edge_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            edge_d = edge_q + CNT_W'(1);
          end
        end
        // Result is loaded on the way into DONE so it is visible with valid.
        if (gate_q == GATE_LAST) begin
          count_d    = edge_d;
          overflow_d = ovf_d;
          state_d    = DONE;
        end else begin
          gate_d = gate_q + GATE_W'(1);
        end
      end
      DONE: begin
`ifdef RELAX_OSC_FREQ_CONT_EN
        state_d = ARM;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      gate_q     <= '0;
      edge_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.valid    = (state_q == DONE);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_relax_osc_freq_counter.sv
// Scoreboard bench for relax_osc_freq_counter: expected results are queued at start
// and checked by a monitor on each valid strobe.
module tb_relax_osc_freq_counter;

  localparam int G  = 100;
  localparam int CW = 4;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          ovf;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   osc_period = 0;
  logic osc_manual = 1'b0;
  exp_t exp_q[$];

  relax_osc_freq_counter_if #(.CNT_W(CW)) bus_if ();

  relax_osc_freq_counter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic osc_gen();
    int phase = 0;
    forever begin
      @(negedge clk);
      #2;
      if (osc_period == 0) begin
        bus_if.osc_in = osc_manual;
        phase = 0;
      end else begin
        if (phase >= osc_period - 1) phase = 0;
        else phase++;
        bus_if.osc_in = (phase < osc_period / 2);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("result cycle %0d count %0d overflow %0d", cyc, bus_if.count, bus_if.overflow);
          n_cmp++;
          if (bus_if.count !== e.cnt) begin
            n_err++;
            $display("FAIL count: got %0d, required %0d", bus_if.count, e.cnt);
          end
          n_cmp++;
          if (bus_if.overflow !== e.ovf) begin
            n_err++;
            $display("FAIL overflow: got %0d, required %0d", bus_if.overflow, e.ovf);
          end
          n_cmp++;
          if (cyc !== e.due) begin
            n_err++;
            $display("FAIL valid_cycle: got %0d, required %0d", cyc, e.due);
          end
        end
      end
    end
  endtask

  task automatic pulse_start(output int e_cyc);
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    e_cyc = cyc;
  endtask

  task automatic push_exp(input logic [CW-1:0] c, input logic o, input int due);
    exp_t e;
    e.cnt = c;
    e.ovf = o;
    e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    osc_period = 2;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_if.busy, bus_if.valid, bus_if.overflow} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: busy/valid/ovf=%b, required 000",
               {bus_if.busy, bus_if.valid, bus_if.overflow});
    end
    n_cmp++;
    if (bus_if.count !== '0) begin
      n_err++;
      $display("FAIL reset_count: got %0d, required 0", bus_if.count);
    end
    rst = 1'b0;
    osc_period = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_if.busy, bus_if.valid} !== 2'b00) begin
        n_err++;
        $display("FAIL idle_quiet: busy/valid=%b at cycle %0d, required 00",
                 {bus_if.busy, bus_if.valid}, cyc);
      end
    end
  endtask

  task automatic test_nominal();
    int e;
    bit ok;
    osc_period = 10;
    repeat (40) @(negedge clk);
    pulse_start(e);
    push_exp(CW'(10), 1'b0, e + G + 1);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_gate: got %b, required 1", bus_if.busy);
    end
    wait_drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL nominal_timeout: no valid, required one");
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus_if.busy, bus_if.count} !== {1'b0, CW'(10)}) begin
      n_err++;
      $display("FAIL after_done: busy=%b count=%0d, required busy=0 count=10",
               bus_if.busy, bus_if.count);
    end
  endtask

  task automatic test_saturation();
    int e;
    bit ok;
    osc_period = 4;
    repeat (40) @(negedge clk);
    pulse_start(e);
    push_exp(CW'(15), 1'b1, e + G + 1);
    wait_drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL sat_timeout: no valid, required one");
    end
    osc_period = 20;
    repeat (60) @(negedge clk);
    pulse_start(e);
    push_exp(CW'(5), 1'b0, e + G + 1);
    wait_drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL slow_timeout: no valid, required one");
    end
  endtask

  task automatic test_boundary();
    int e;
    bit ok;
    osc_period = 0;
    osc_manual = 1'b0;
    repeat (10) @(negedge clk);
    // rise lands in ARM: not counted
    osc_manual = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    e = cyc;
    push_exp(CW'(0), 1'b0, e + G + 1);
    repeat (5) @(negedge clk);
    osc_manual = 1'b0;
    wait_drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL arm_edge_timeout: no valid, required one"); end
    repeat (10) @(negedge clk);
    // rise lands in first GATE cycle: counted
    @(negedge clk);
    bus_if.start = 1'b1;
    osc_manual = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    e = cyc;
    push_exp(CW'(1), 1'b0, e + G + 1);
    repeat (5) @(negedge clk);
    osc_manual = 1'b0;
    wait_drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL first_edge_timeout: no valid, required one"); end
    repeat (10) @(negedge clk);
    // rise lands in last GATE cycle: counted
    pulse_start(e);
    push_exp(CW'(1), 1'b0, e + G + 1);
    while (cyc < e + G - 2) @(negedge clk);
    osc_manual = 1'b1;
    wait_drain(200, ok);
    osc_manual = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL last_edge_timeout: no valid, required one"); end
    repeat (10) @(negedge clk);
    // rise lands in DONE: not counted
    pulse_start(e);
    push_exp(CW'(0), 1'b0, e + G + 1);
    while (cyc < e + G - 1) @(negedge clk);
    osc_manual = 1'b1;
    wait_drain(200, ok);
    osc_manual = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL done_edge_timeout: no valid, required one"); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_start_during_gate();
    int e;
    int d;
    bit ok;
    osc_period = 10;
    repeat (40) @(negedge clk);
    pulse_start(e);
    push_exp(CW'(10), 1'b0, e + G + 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_start(d);
      repeat (10) @(negedge clk);
    end
    wait_drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL extra_start_timeout: no valid, required one");
    end
    repeat (150) @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL extra_start_busy: got %b, required 0", bus_if.busy);
    end
  endtask

  task automatic test_reset_mid_gate();
    int e;
    osc_period = 10;
    pulse_start(e);
    while (cyc < e + 50) @(negedge clk);
    n_cmp++;
    if ({bus_if.busy, bus_if.count} !== {1'b1, CW'(10)}) begin
      n_err++;
      $display("FAIL held_count: busy=%b count=%0d, required busy=1 count=10",
               bus_if.busy, bus_if.count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus_if.busy, bus_if.valid, bus_if.overflow, bus_if.count} !== {3'b000, CW'(0)}) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b valid=%b ovf=%b count=%0d, required all 0",
               bus_if.busy, bus_if.valid, bus_if.overflow, bus_if.count);
    end
    repeat (150) @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_busy: got %b, required 0", bus_if.busy);
    end
  endtask

  task automatic test_continuous();
    int e;
    bit ok;
    osc_period = 10;
    repeat (40) @(negedge clk);
    pulse_start(e);
    for (int i = 0; i < 3; i++) push_exp(CW'(10), 1'b0, e + G + 1 + i * (G + 2));
    wait_drain(500, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL cont_timeout: %0d results missing, required 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL cont_busy: got %b, required 1", bus_if.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL cont_reset_busy: got %b, required 0", bus_if.busy);
    end
    repeat (150) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.osc_in = 1'b0;
    fork
      osc_gen();
      monitor();
    join_none
    test_reset();
`ifdef RELAX_OSC_FREQ_CONT_EN
    test_continuous();
`else
    test_nominal();
    test_saturation();
    test_boundary();
    test_nominal();
    test_start_during_gate();
    test_reset_mid_gate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
